// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// instr_pkg : instruction format, field positions and loader states shared by
//             the instruction decoder and the program loader.
// Revision  : 1.0
// ============================================================================
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_ARITH = 2'd0,
    FMT_MEM   = 2'd1,
    FMT_CTRL  = 2'd2,
    FMT_ILL   = 2'd3
  } fmt_e;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 29;
  localparam int R0_MSB   = 28;
  localparam int R0_LSB   = 24;
  localparam int R1_MSB   = 23;
  localparam int R1_LSB   = 19;
  localparam int R2_MSB   = 18;
  localparam int R2_LSB   = 14;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// instr_pack : combinational field -> 32-bit instruction word encoder.
// Revision   : 1.0
// ============================================================================
module instr_pack
  import instr_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [2:0]  opcode,
  input  logic [4:0]  reg0,
  input  logic [4:0]  reg1,
  input  logic [4:0]  reg2,
  input  logic [15:0] addr,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    word[OPC_MSB:OPC_LSB] = opcode;
    word[R0_MSB:R0_LSB]   = reg0;
    case (fmt_e'(fmt))
      FMT_ARITH: begin
        word[R1_MSB:R1_LSB] = reg1;
        word[R2_MSB:R2_LSB] = reg2;
      end
      FMT_MEM: begin
        word[ADDR_MSB:ADDR_LSB] = addr;
      end
      FMT_CTRL: begin
        // R1 and ADDR do not overlap; bits 18:16 stay zero
        word[R1_MSB:R1_LSB]     = reg1;
        word[ADDR_MSB:ADDR_LSB] = addr;
      end
      default: begin
        word = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// instr_encoder_loader : packs instruction field bundles into ISA words and
//                        writes them to sequential instruction-memory slots.
// Revision             : 1.0
// ============================================================================
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [2:0]        in_opcode,
  input  logic [4:0]        in_reg0,
  input  logic [4:0]        in_reg1,
  input  logic [4:0]        in_reg2,
  input  logic [15:0]       in_addr,
  input  logic              in_last,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_fmt,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_ptr_max = {ADDR_W{1'b1}};

  ld_state_e         r_state;
  ld_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_err_fmt;
  logic              r_err_ovf;

  logic [31:0]       w_word;
  logic              w_start;
  logic              w_xfer;
  logic              w_legal;
  logic              w_ack;

  assign w_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_xfer  = in_valid && (r_state == ST_LOAD);
  assign w_legal = (fmt_e'(in_fmt) != FMT_ILL);
  assign w_ack   = mem_ack && (r_state == ST_WRITE);

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .reg0   (in_reg0),
    .reg1   (in_reg1),
    .reg2   (in_reg2),
    .addr   (in_addr),
    .word   (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_xfer) begin
          if (w_legal)      w_state_nxt = ST_WRITE;
          else if (in_last) w_state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        // the pointer never wraps: a full memory ends the session
        if (w_ack) w_state_nxt = (r_last || (r_ptr == c_ptr_max)) ? ST_DONE : ST_LOAD;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= c_base;
      r_count   <= '0;
      r_word    <= '0;
      r_last    <= 1'b0;
      r_err_fmt <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_start) begin
        r_ptr     <= c_base;
        r_count   <= '0;
        r_err_fmt <= 1'b0;
        r_err_ovf <= 1'b0;
      end
      if (w_xfer) begin
        if (w_legal) begin
          r_word <= w_word;
          r_last <= in_last;
        end else begin
          r_err_fmt <= 1'b1;
        end
      end
      if (w_ack) begin
        r_count <= r_count + (ADDR_W+1)'(1);
        if (!r_last) begin
          if (r_ptr == c_ptr_max) r_err_ovf <= 1'b1;
          else                    r_ptr     <= r_ptr + ADDR_W'(1);
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign mem_req   = (r_state == ST_WRITE);
  assign mem_addr  = r_ptr;
  assign mem_wdata = r_word;
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_WRITE);
  assign done      = (r_state == ST_DONE);
  assign count     = r_count;
  assign err_fmt   = r_err_fmt;
  assign err_ovf   = r_err_ovf;

endmodule
`default_nettype wire
